// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
//   Shared definitions for the SSD1306-class OLED path on the Zanagotchi
//   board: the SPI transmit engine state encoding, data/command select
//   constants and the default panel timing constants that the display
//   controller's command tables also reference.
// ---------------------------------------------------------------------------
package oled_pkg;

   // Engine state: panel reset low, panel reset wait, idle, shifting a byte.
   typedef enum logic [1:0] {
      RST_LOW  = 2'd0,
      RST_WAIT = 2'd1,
      IDLE     = 2'd2,
      SHIFT    = 2'd3
   } oled_state_e;

   // Value driven on the panel D/C# pin.
   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

   // Default timing: system clocks per SCLK half-period, clocks of panel
   // reset held low, clocks waited after reset release.
   localparam int DEF_CLK_DIV           = 4;
   localparam int DEF_RESET_LOW_CYCLES  = 1000;
   localparam int DEF_RESET_WAIT_CYCLES = 1000;

   // Largest of three timing values; sizes the shared delay counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/oled_spi_tx.sv
// ---------------------------------------------------------------------------
// oled_spi_tx
//   Byte-level SPI (mode 0, MSB first) transmit engine and panel power-up
//   sequencer for the SSD1306-class OLED. After rst deasserts it holds the
//   panel in reset, waits for it to come up, then accepts one command/data
//   byte at a time over a valid/ready handshake.
//
// Parameters
//   CLK_DIV            system clocks per SCLK half-period (>= 1)
//   RESET_LOW_CYCLES   clocks io_reset is held low after rst deasserts (>= 1)
//   RESET_WAIT_CYCLES  clocks from io_reset rising until init_done (>= 1)
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   tx_data    in   byte to send, MSB first
//   tx_dc      in   0 = command, 1 = data
//   tx_valid   in   byte offered
//   tx_ready   out  engine idle and panel initialised
//   tx_done    out  one-cycle pulse after the last bit is clocked out
//   init_done  out  panel reset sequence complete, sticky until rst
//   io_sclk    out  SPI clock, idle low
//   io_sdin    out  SPI data
//   io_cs      out  active-low chip select
//   io_dc      out  data/command select
//   io_reset   out  active-low panel reset
// ---------------------------------------------------------------------------
module oled_spi_tx
   import oled_pkg::*;
#(
   parameter int CLK_DIV           = DEF_CLK_DIV,
   parameter int RESET_LOW_CYCLES  = DEF_RESET_LOW_CYCLES,
   parameter int RESET_WAIT_CYCLES = DEF_RESET_WAIT_CYCLES
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_dc,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_done,
   output logic       init_done,
   output logic       io_sclk,
   output logic       io_sdin,
   output logic       io_cs,
   output logic       io_dc,
   output logic       io_reset
);

   localparam int CNT_MAX = max3(CLK_DIV, RESET_LOW_CYCLES, RESET_WAIT_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   // Terminal counts: each phase ends on the edge that sees the last value.
   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(RESET_LOW_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESET_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

   oled_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;       // shared reset-delay / half-period counter
   logic [2:0]       bit_cnt_q;   // bits already completed in this byte
   logic [7:0]       shreg_q;     // remaining bits, next one in bit 7
   logic             sclk_q;
   logic             sdin_q;
   logic             cs_q;
   logic             dc_q;
   logic             reset_q;
   logic             ready_q;
   logic             done_q;
   logic             init_q;

   // NOTE: every register here is updated with <= so that all of them see
   // the pre-edge values of each other; blocking assignments in a clocked
   // block would make results depend on statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= RST_LOW;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         sclk_q    <= 1'b0;
         sdin_q    <= 1'b0;
         cs_q      <= 1'b1;
         dc_q      <= DC_CMD;
         reset_q   <= 1'b0;
         ready_q   <= 1'b0;
         done_q    <= 1'b0;
         init_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            RST_LOW: begin
               if (cnt_q == LOW_LAST) begin
                  state_q <= RST_WAIT;
                  cnt_q   <= '0;
                  reset_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            RST_WAIT: begin
               if (cnt_q == WAIT_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  ready_q <= 1'b1;
                  init_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            IDLE: begin
               // ready_q is 1 throughout IDLE, so tx_valid alone accepts.
               if (tx_valid) begin
                  state_q   <= SHIFT;
                  cnt_q     <= '0;
                  bit_cnt_q <= '0;
                  sdin_q    <= tx_data[7];
                  shreg_q   <= {tx_data[6:0], 1'b0};
                  dc_q      <= tx_dc;
                  cs_q      <= 1'b0;
                  ready_q   <= 1'b0;
               end
            end

            SHIFT: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q <= '0;
                  if (!sclk_q) begin
                     // Rising edge: panel samples the bit already on sdin.
                     sclk_q <= 1'b1;
                  end else begin
                     // Falling edge: the only place sdin moves mid-byte.
                     sclk_q <= 1'b0;
                     if (bit_cnt_q == 3'd7) begin
                        state_q <= IDLE;
                        cs_q    <= 1'b1;
                        sdin_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        sdin_q    <= shreg_q[7];
                        shreg_q   <= {shreg_q[6:0], 1'b0};
                     end
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            default: state_q <= RST_LOW;
         endcase
      end
   end

   assign tx_ready  = ready_q;
   assign tx_done   = done_q;
   assign init_done = init_q;
   assign io_sclk   = sclk_q;
   assign io_sdin   = sdin_q;
   assign io_cs     = cs_q;
   assign io_dc     = dc_q;
   assign io_reset  = reset_q;

endmodule

// File: doc/oled_spi_tx.md
# oled_spi_tx

Byte-level SPI transmit engine and panel power-up sequencer for the SSD1306-class OLED on the Zanagotchi board. It sits directly downstream of the display controller. It accepts one command or data byte at a time over a valid/ready handshake and drives the panel pins `io_sclk`, `io_sdin`, `io_cs`, `io_dc` and `io_reset`. It also owns the panel hardware-reset pulse and withholds `tx_ready` until the panel is ready.

## Interface
- `CLK_DIV`, default 4: system clocks per SCLK half-period; minimum 1.
- `RESET_LOW_CYCLES`, default 1000: clocks `io_reset` is held low after `rst` deasserts.
- `RESET_WAIT_CYCLES`, default 1000: clocks from `io_reset` rising until `init_done`.
- `clk`  in  1  system clock; single clock domain, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  8  byte to send, MSB first.
- `tx_dc`  in  1  0 = command, 1 = data; driven onto `io_dc` for the whole byte.
- `tx_valid`  in  1  byte offered.
- `tx_ready`  out  1  engine idle and initialised; transfer accepted when `tx_valid & tx_ready`.
- `tx_done`  out  1  one-cycle pulse when the last bit has been clocked out.
- `init_done`  out  1  panel reset sequence complete; stays 1 until `rst`.
- `io_sclk`  out  1  SPI clock, mode 0 (idle low, sample on rising edge).
- `io_sdin`  out  1  SPI data.
- `io_cs`  out  1  active-low chip select.
- `io_dc`  out  1  data/command select.
- `io_reset`  out  1  active-low panel reset.

## Operation
- Reset values, held while `rst` = 1:
  - `io_sclk`=0, `io_sdin`=0, `io_cs`=1, `io_dc`=0, `io_reset`=0.
  - `tx_ready`=0, `tx_done`=0, `init_done`=0.
  - State RST_LOW with delay counter cleared.
- States and transitions:
  - RST_LOW: `io_reset`=0. After `RESET_LOW_CYCLES` clocks with `rst`=0, go to RST_WAIT.
  - RST_WAIT: `io_reset`=1. After `RESET_WAIT_CYCLES` clocks, go to IDLE.
  - IDLE: `tx_ready`=1, `init_done`=1. On `tx_valid`, go to SHIFT.
  - SHIFT: clock out 8 bits, then return to IDLE.
- Accept: `tx_data` and `tx_dc` are captured into a shift register and dc latch on the accepting edge. Later changes to the inputs are ignored until the next accept.
- Bit order: MSB first. `io_sdin` changes only while `io_sclk` is low (on the falling-edge cycle). It is stable across every rising edge.
- While SHIFT is active: `io_cs`=0 and `io_dc` = captured dc. Both are stable for the whole byte.
- End of byte: `io_cs` returns to 1, `io_sdin` returns to 0, `io_dc` holds its last value.
- `tx_valid` in RST_LOW, RST_WAIT or SHIFT is ignored; no byte is queued.
- Counter width is `$clog2` of the largest timing parameter plus one. Counters never wrap within a phase.
- `rst` asserted mid-byte or mid-sequence:
  - The transfer is aborted; `io_cs`=1 on the next edge.
  - No `tx_done` is generated.
  - The full reset sequence restarts.

## Timing
- Let E0 be the accepting edge.
- After E0: `io_cs`=0, `io_dc`=dc, `io_sdin`=bit7, `io_sclk`=0.
- Rising SCLK edges for bit 7−i (i = 0..7) occur at E((2i+1)·CLK_DIV).
- Falling SCLK edges occur at E((2i+2)·CLK_DIV).
- At E(16·CLK_DIV):
  - `io_sclk`=0, `io_cs`=1.
  - `tx_done`=1 for one cycle.
  - `tx_ready`=1 (back in IDLE).
- Next accept is possible at E(16·CLK_DIV+1) at the earliest. Minimum byte period is 16·CLK_DIV+1 clocks, so `io_cs` is high for at least 1 clock between bytes.
- Initialisation: `io_reset` rises exactly `RESET_LOW_CYCLES` clocks after the first edge with `rst`=0. `init_done` and `tx_ready` rise `RESET_WAIT_CYCLES` clocks after that.

## Structure
- Shared package `oled_pkg` holds:
  - State encoding (RST_LOW, RST_WAIT, IDLE, SHIFT).
  - DC constants (`DC_CMD`=0, `DC_DATA`=1).
  - Default timing constants, reused by the display controller's command tables.
- Flat implementation: one state register, one shared delay/half-period counter, a 3-bit bit counter and an 8-bit shift register. No sub-module is needed.

## Test plan
All scenarios use `CLK_DIV`=2, `RESET_LOW_CYCLES`=4, `RESET_WAIT_CYCLES`=3.
- Power-up: release `rst` → `io_reset` low for exactly 4 clocks, then high; `init_done`/`tx_ready` rise 3 clocks later; `io_cs`=1 throughout.
- Single byte: offer `tx_data`=0xA5, `tx_dc`=0 → `io_cs` low for 32 clocks; SDIN sampled on the 8 rising edges reads 1,0,1,0,0,1,0,1; `io_dc`=0; `tx_done` pulses at E32.
- Back-to-back data: hold `tx_valid`=1 with 0xFF then 0x00, `tx_dc`=1 → second accept at E33, `io_cs` high exactly 1 clock between bytes, second byte reads all zeros, `io_dc`=1 throughout.
- Input stability: change `tx_data` to 0x00 one clock after accepting 0x81 → panel still receives 0x81.
- Early offer: assert `tx_valid` during RST_WAIT → no SCLK activity and `tx_ready`=0 until `init_done`; the first transfer starts only after `init_done`.
- Mid-byte reset: assert `rst` at E10 of a transfer → `io_cs`=1 and `io_reset`=0 on the next edge, no `tx_done`, and the full 4+3 sequence repeats.
